// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that owns the D input and load enable of one shared WIDTH-bit register.
// Optional REG_ARB_TIMEOUT_EN bounds any ownership to MAX_HOLD consecutive cycles.
module reg_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]        q,
  output logic                    busy,
  output logic                    timeout
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [OW-1:0]    owner_reg, owner_next;
  logic [OW-1:0]    rr_reg, rr_next, rr_adv, arb_ptr, win_idx;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] wslice [NREQ];
  logic [NREQ-1:0]  hi_mask, masked_req, pick_src, win_onehot;
  logic             win_found, owned, owner_req, owner_lock, keep, force_rel;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign wslice[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  assign owned      = (state_reg != IDLE);
  assign owner_req  = req[owner_reg];
  assign owner_lock = lock[owner_reg];
  assign keep       = owned && owner_req && owner_lock && !force_rel;

  // On release the search starts just past the outgoing owner, not at the stale pointer.
  assign rr_adv  = (owner_reg == OW'(NREQ-1)) ? '0 : owner_reg + 1'b1;
  assign arb_ptr = owned ? rr_adv : rr_reg;
  assign hi_mask = ~((NREQ'(1) << arb_ptr) - NREQ'(1));

  always_comb begin
    masked_req = req & hi_mask;
    pick_src   = (|masked_req) ? masked_req : req;
    win_found  = |req;
    win_idx    = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (pick_src[i]) win_idx = OW'(i);
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    q_next     = q_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          gnt_next   = win_onehot;
          owner_next = win_idx;
        end
      end
      GRANT, LOCKED: begin
        if (owner_req) q_next = wslice[owner_reg];
        if (keep) begin
          state_next = LOCKED;
        end else begin
          rr_next = rr_adv;
          if (win_found) begin
            state_next = GRANT;
            gnt_next   = win_onehot;
            owner_next = win_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      rr_reg    <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      q_reg     <= q_next;
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt_reg;
  logic          timeout_reg;

  // Last permitted owned cycle: the edge ending it writes, then releases.
  assign force_rel = (hold_cnt_reg == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= keep ? hold_cnt_reg + 1'b1 : '0;
      timeout_reg  <= owned && owner_req && owner_lock && force_rel;
    end
  end

  assign timeout = timeout_reg;
`else
  // MAX_HOLD has no effect here: locked ownership never expires.
  assign force_rel = (MAX_HOLD < 0);
  assign timeout   = 1'b0;
`endif

  assign gnt   = gnt_reg;
  assign owner = owner_reg;
  assign q     = q_reg;
  assign busy  = |gnt_reg;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: stimulus pushes per-cycle expected outputs into a
// scoreboard queue; a monitor pops and compares one entry after each clock edge.
module tb_reg_share_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MH = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   lock = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           busy;
  logic           timeout;

  typedef struct {
    string        tag;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic [W-1:0] q;
    logic         busy;
    logic         to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(.WIDTH(W), .NREQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .busy(busy), .timeout(timeout)
  );

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] s3, s2, s1, s0);
    return {s3, s2, s1, s0};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input string tag, input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [N*W-1:0] wd, input logic [N-1:0] eg, input logic [1:0] eo,
                      input logic [W-1:0] eq, input logic et);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    lock  = l;
    wdata = wd;
    e.tag = tag; e.gnt = eg; e.owner = eo; e.q = eq; e.busy = |eg; e.to = et;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (gnt !== e.gnt || owner !== e.owner || q !== e.q || busy !== e.busy || timeout !== e.to) begin
        bad++;
        $display("FAIL %s: got gnt=%b owner=%0d q=%h busy=%b timeout=%b, want gnt=%b owner=%0d q=%h busy=%b timeout=%b",
                 e.tag, gnt, owner, q, busy, timeout, e.gnt, e.owner, e.q, e.busy, e.to);
      end else begin
        $display("ok   %s: gnt=%b owner=%0d q=%h busy=%b timeout=%b", e.tag, gnt, owner, q, busy, timeout);
      end
    end
  end

  initial begin
    // Reset held with random requests, then released with nothing requesting.
    for (int i = 0; i < 10; i++)
      step($sformatf("reset%0d", i), 1'b1, N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
           mk(8'h5A, 8'h5A, 8'h5A, 8'h5A), 4'b0000, 2'd0, 8'h00, 1'b0);
    step("idle0", 1'b0, 4'b0000, 4'b0000, '0, 4'b0000, 2'd0, 8'h00, 1'b0);
    step("idle1", 1'b0, 4'b0000, 4'b0000, '0, 4'b0000, 2'd0, 8'h00, 1'b0);

    // Single requester: grant, write, then release to IDLE.
    step("single_gnt",  1'b0, 4'b0100, 4'b0000, mk(8'h00, 8'hA5, 8'h00, 8'h00), 4'b0100, 2'd2, 8'h00, 1'b0);
    step("single_wr",   1'b0, 4'b0100, 4'b0000, mk(8'h00, 8'hA5, 8'h00, 8'h00), 4'b0100, 2'd2, 8'hA5, 1'b0);
    step("single_idle", 1'b0, 4'b0000, 4'b0000, mk(8'h00, 8'hA5, 8'h00, 8'h00), 4'b0000, 2'd2, 8'hA5, 1'b0);

    // Round robin from a freshly reset pointer, including the wrap back to 0.
    step("rr_reset", 1'b1, 4'b0000, 4'b0000, '0, 4'b0000, 2'd0, 8'h00, 1'b0);
    step("rr_g0", 1'b0, 4'b1111, 4'b0000, mk(8'h13, 8'h12, 8'h11, 8'h10), 4'b0001, 2'd0, 8'h00, 1'b0);
    step("rr_g1", 1'b0, 4'b1111, 4'b0000, mk(8'h13, 8'h12, 8'h11, 8'h10), 4'b0010, 2'd1, 8'h10, 1'b0);
    step("rr_g2", 1'b0, 4'b1111, 4'b0000, mk(8'h13, 8'h12, 8'h11, 8'h10), 4'b0100, 2'd2, 8'h11, 1'b0);
    step("rr_g3", 1'b0, 4'b1111, 4'b0000, mk(8'h13, 8'h12, 8'h11, 8'h10), 4'b1000, 2'd3, 8'h12, 1'b0);
    step("rr_wrap", 1'b0, 4'b1111, 4'b0000, mk(8'h13, 8'h12, 8'h11, 8'h10), 4'b0001, 2'd0, 8'h13, 1'b0);

    // Owner 0 drops its request: no write, requester 1 wins and then locks for 5 granted cycles.
    step("lk_handoff", 1'b0, 4'b1010, 4'b0010, mk(8'h00, 8'h00, 8'h30, 8'h00), 4'b0010, 2'd1, 8'h13, 1'b0);
    step("lk_1", 1'b0, 4'b1010, 4'b0010, mk(8'h00, 8'h00, 8'h31, 8'h00), 4'b0010, 2'd1, 8'h31, 1'b0);
    step("lk_2", 1'b0, 4'b1010, 4'b0010, mk(8'h00, 8'h00, 8'h32, 8'h00), 4'b0010, 2'd1, 8'h32, 1'b0);
    step("lk_3", 1'b0, 4'b1010, 4'b0010, mk(8'h00, 8'h00, 8'h33, 8'h00), 4'b0010, 2'd1, 8'h33, 1'b0);
    step("lk_4", 1'b0, 4'b1010, 4'b0010, mk(8'h00, 8'h00, 8'h34, 8'h00), 4'b0010, 2'd1, 8'h34, 1'b0);
    step("lk_drop", 1'b0, 4'b1010, 4'b0000, mk(8'h00, 8'h00, 8'h35, 8'h00), 4'b1000, 2'd3, 8'h35, 1'b0);

    // Reset during LOCKED suppresses that edge's write.
    step("mid_lock", 1'b0, 4'b1000, 4'b1000, mk(8'h44, 8'h00, 8'h00, 8'h00), 4'b1000, 2'd3, 8'h44, 1'b0);
    step("mid_reset", 1'b1, 4'b1000, 4'b1000, mk(8'h55, 8'h00, 8'h00, 8'h00), 4'b0000, 2'd0, 8'h00, 1'b0);
    step("post_reset", 1'b0, 4'b0000, 4'b0000, mk(8'h55, 8'h00, 8'h00, 8'h00), 4'b0000, 2'd0, 8'h00, 1'b0);

    // Requester 0 locks indefinitely while requester 2 waits.
    step("to_gnt", 1'b0, 4'b0101, 4'b0001, mk(8'h00, 8'h70, 8'h00, 8'h60), 4'b0001, 2'd0, 8'h00, 1'b0);
    for (int k = 1; k < MH; k++)
      step($sformatf("to_hold%0d", k), 1'b0, 4'b0101, 4'b0001, mk(8'h00, 8'h70, 8'h00, W'(8'h60 + k)),
           4'b0001, 2'd0, W'(8'h60 + k), 1'b0);
`ifdef REG_ARB_TIMEOUT_EN
    step("to_fire", 1'b0, 4'b0101, 4'b0001, mk(8'h00, 8'h70, 8'h00, 8'h66), 4'b0100, 2'd2, 8'h66, 1'b1);
    step("to_next", 1'b0, 4'b0100, 4'b0000, mk(8'h00, 8'h77, 8'h00, 8'h67), 4'b0100, 2'd2, 8'h77, 1'b0);
    step("to_idle", 1'b0, 4'b0000, 4'b0000, mk(8'h00, 8'h77, 8'h00, 8'h67), 4'b0000, 2'd2, 8'h77, 1'b0);
`else
    step("no_to", 1'b0, 4'b0101, 4'b0001, mk(8'h00, 8'h70, 8'h00, 8'h66), 4'b0001, 2'd0, 8'h66, 1'b0);
    step("no_to_rel", 1'b0, 4'b0100, 4'b0000, mk(8'h00, 8'h77, 8'h00, 8'h67), 4'b0100, 2'd2, 8'h66, 1'b0);
    step("no_to_idle", 1'b0, 4'b0000, 4'b0000, mk(8'h00, 8'h77, 8'h00, 8'h67), 4'b0000, 2'd2, 8'h66, 1'b0);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
